pico_axi_wdata_router: RTL and testbench

// Write-data stage downstream of the AW arbiter. Records, in grant order, the slave port

---
 rtl/pico_axi_wdata_router.sv | 129 ++++++++++++
 tb/tb_pico_axi_wdata_router.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_axi_wdata_router.sv
// Write-data router: replays the AW grant order as W burst ownership so master-side
// W beats always follow the order in which their AW beats were issued.
module pico_axi_wdata_router #(
  parameter int C_NUM_SLAVE_PORTS     = 4,
  parameter int LOG_C_NUM_SLAVE_PORTS = 2,
  parameter int C_DATA_WIDTH          = 128,
  parameter int ORDER_DEPTH           = 16,
  parameter int LOG_ORDER_DEPTH       = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          aw_grant_valid,
  input  logic [LOG_C_NUM_SLAVE_PORTS-1:0]              aw_grant_slave,
  output logic                                          aw_grant_ready,
  input  logic [C_NUM_SLAVE_PORTS-1:0]                  s_axi_wvalid,
  input  logic [C_NUM_SLAVE_PORTS*C_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_NUM_SLAVE_PORTS*C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic [C_NUM_SLAVE_PORTS-1:0]                  s_axi_wlast,
  output logic [C_NUM_SLAVE_PORTS-1:0]                  s_axi_wready,
  output logic                                          m_axi_wvalid,
  output logic [C_DATA_WIDTH-1:0]                       m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0]                     m_axi_wstrb,
  output logic                                          m_axi_wlast,
  input  logic                                          m_axi_wready,
  output logic [LOG_ORDER_DEPTH:0]                      order_count
);

  localparam int STRB_WIDTH = C_DATA_WIDTH / 8;
  localparam logic [LOG_ORDER_DEPTH:0]   FULL_COUNT = (LOG_ORDER_DEPTH+1)'(ORDER_DEPTH);
  localparam logic [LOG_ORDER_DEPTH:0]   ZERO_COUNT = (LOG_ORDER_DEPTH+1)'(32'd0);
  localparam logic [LOG_ORDER_DEPTH:0]   COUNT_ONE  = (LOG_ORDER_DEPTH+1)'(32'd1);
  localparam logic [LOG_ORDER_DEPTH-1:0] PTR_ZERO   = (LOG_ORDER_DEPTH)'(32'd0);
  localparam logic [LOG_ORDER_DEPTH-1:0] PTR_ONE    = (LOG_ORDER_DEPTH)'(32'd1);

  logic [LOG_C_NUM_SLAVE_PORTS-1:0] order_mem_r [ORDER_DEPTH];
  logic [LOG_ORDER_DEPTH-1:0]       wr_ptr_r;
  logic [LOG_ORDER_DEPTH-1:0]       rd_ptr_r;
  logic [LOG_ORDER_DEPTH:0]         count_r;
  logic                             m_wvalid_r;
  logic [C_DATA_WIDTH-1:0]          m_wdata_r;
  logic [STRB_WIDTH-1:0]            m_wstrb_r;
  logic                             m_wlast_r;

  logic [LOG_C_NUM_SLAVE_PORTS-1:0] sel_s;
  logic                             head_valid_s;
  logic                             load_s;
  logic                             push_s;
  logic                             accept_s;
  logic                             pop_s;
  logic [C_NUM_SLAVE_PORTS-1:0]     wready_s;

  // Head selection, per-slave ready decode and FIFO handshakes
  always_comb begin
    sel_s        = order_mem_r[rd_ptr_r];
    head_valid_s = (count_r != ZERO_COUNT);
    load_s       = !m_wvalid_r || m_axi_wready;
    push_s       = aw_grant_valid && (count_r != FULL_COUNT);
    wready_s     = {C_NUM_SLAVE_PORTS{1'b0}};
    for (int k = 0; k < C_NUM_SLAVE_PORTS; k++) begin
      if (load_s && head_valid_s && (sel_s == LOG_C_NUM_SLAVE_PORTS'(k))) begin
        wready_s[k] = 1'b1;
      end else begin
        wready_s[k] = 1'b0;
      end
    end
    accept_s = s_axi_wvalid[sel_s] && wready_s[sel_s];
    pop_s    = accept_s && s_axi_wlast[sel_s];
  end

  // Order FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORDER_DEPTH; i++) begin
        order_mem_r[i] <= {LOG_C_NUM_SLAVE_PORTS{1'b0}};
      end
    end else if (push_s) begin
      order_mem_r[wr_ptr_r] <= aw_grant_slave;
    end
  end

  // Order FIFO pointers and occupancy; power-of-2 depth makes the wrap implicit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= ZERO_COUNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Master W output register; holds its beat while the master stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wvalid_r <= 1'b0;
      m_wdata_r  <= {C_DATA_WIDTH{1'b0}};
      m_wstrb_r  <= {STRB_WIDTH{1'b0}};
      m_wlast_r  <= 1'b0;
    end else if (load_s) begin
      if (accept_s) begin
        m_wvalid_r <= 1'b1;
        m_wdata_r  <= s_axi_wdata[int'(sel_s)*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_wstrb_r  <= s_axi_wstrb[int'(sel_s)*STRB_WIDTH +: STRB_WIDTH];
        m_wlast_r  <= s_axi_wlast[sel_s];
      end else begin
        m_wvalid_r <= 1'b0;
      end
    end
  end

  assign aw_grant_ready = (count_r != FULL_COUNT);
  assign s_axi_wready   = wready_s;
  assign m_axi_wvalid   = m_wvalid_r;
  assign m_axi_wdata    = m_wdata_r;
  assign m_axi_wstrb    = m_wstrb_r;
  assign m_axi_wlast    = m_wlast_r;
  assign order_count    = count_r;

endmodule

// File: tb/tb_pico_axi_wdata_router.sv
// Bench for pico_axi_wdata_router: grant-order queue and per-slave burst lists predict
// ready, occupancy and the master W beat stream.
module tb_pico_axi_wdata_router;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int BW = DW + SW + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           aw_grant_valid;
  logic [1:0]     aw_grant_slave;
  logic           aw_grant_ready;
  logic [N-1:0]   s_axi_wvalid;
  logic [N*DW-1:0] s_axi_wdata;
  logic [N*SW-1:0] s_axi_wstrb;
  logic [N-1:0]   s_axi_wlast;
  logic [N-1:0]   s_axi_wready;
  logic           m_axi_wvalid;
  logic [DW-1:0]  m_axi_wdata;
  logic [SW-1:0]  m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_wready;
  logic [4:0]     order_count;

  pico_axi_wdata_router dut (
    .clk(clk), .rst_n(rst_n),
    .aw_grant_valid(aw_grant_valid), .aw_grant_slave(aw_grant_slave),
    .aw_grant_ready(aw_grant_ready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .order_count(order_count)
  );

  always #5 clk = ~clk;

  int total, passed, failed;
  // Each beat is packed as {data, strb, last}
  logic [BW-1:0] src_mem [N][256];
  int            src_n [N];
  int            drv_idx [N];
  int            claim_idx [N];
  logic [1:0]    order_q [$];
  logic [BW-1:0] exp_q [$];
  logic          exp_mvalid;
  logic [N-1:0]  en;
  int            gap_pct;
  bit            pushed;
  int            run_xfer, run_idle;
  int            cnt_before;
  int            kk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_burst(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      src_mem[k][src_n[k]] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom), (i == len - 1)};
      src_n[k]++;
    end
  endtask

  // A granted slave owns the next unclaimed burst of its list, appended in grant order
  task automatic claim(input int k);
    logic [BW-1:0] b;
    bit done;
    done = 1'b0;
    while (!done && claim_idx[k] < src_n[k]) begin
      b = src_mem[k][claim_idx[k]];
      claim_idx[k]++;
      exp_q.push_back(b);
      done = b[0];
    end
  endtask

  task automatic reset_model();
    order_q.delete();
    exp_q.delete();
    exp_mvalid = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_n[k] = 0;
      drv_idx[k] = 0;
      claim_idx[k] = 0;
    end
  endtask

  // One clock: drive slaves at negedge, check just after, advance the model at posedge
  task automatic cycle();
    logic load, acc, pop, push;
    logic [N-1:0] exp_rdy;
    logic [1:0] h;
    logic [BW-1:0] b;
    for (int k = 0; k < N; k++) begin
      if (en[k] && drv_idx[k] < src_n[k] && $urandom_range(99) >= gap_pct) begin
        b = src_mem[k][drv_idx[k]];
        s_axi_wvalid[k] = 1'b1;
        s_axi_wdata[k*DW +: DW] = b[BW-1 -: DW];
        s_axi_wstrb[k*SW +: SW] = b[SW:1];
        s_axi_wlast[k] = b[0];
      end else begin
        s_axi_wvalid[k] = 1'b0;
        s_axi_wlast[k] = 1'b0;
      end
    end
    #1;
    load = !exp_mvalid || m_axi_wready;
    exp_rdy = 4'b0000;
    h = 2'd0;
    if (order_q.size() != 0) h = order_q[0];
    if (order_q.size() != 0 && load) exp_rdy[h] = 1'b1;
    check("s_wready", BW'(s_axi_wready), BW'(exp_rdy));
    check("order_count", BW'(order_count), BW'(order_q.size()));
    check("aw_ready", BW'(aw_grant_ready), BW'(order_q.size() < 16));
    check("m_wvalid", BW'(m_axi_wvalid), BW'(exp_mvalid));
    if (exp_mvalid && m_axi_wready && exp_q.size() != 0) begin
      check("m_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, exp_q.pop_front());
      run_xfer++;
    end else if (run_xfer > 0 && exp_q.size() != 0) begin
      run_idle++;
    end
    acc = (exp_rdy != 4'b0000) && s_axi_wvalid[h];
    b = src_mem[h][drv_idx[h]];
    pop = acc && b[0];
    push = aw_grant_valid && (order_q.size() < 16);
    @(posedge clk);
    if (load) exp_mvalid = acc;
    if (acc) drv_idx[h]++;
    if (pop) void'(order_q.pop_front());
    if (push) begin
      order_q.push_back(aw_grant_slave);
      claim(int'(aw_grant_slave));
    end
    pushed = push;
    @(negedge clk);
  endtask

  task automatic grant(input int k);
    int n;
    aw_grant_valid = 1'b1;
    aw_grant_slave = 2'(k);
    n = 0;
    pushed = 1'b0;
    while (!pushed && n < 40) begin
      cycle();
      n++;
    end
    check("grant_taken", BW'(pushed), BW'(1'b1));
    aw_grant_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    en = 4'hf;
    while ((order_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      m_axi_wready = rnd ? ($urandom_range(99) < 70) : 1'b1;
      cycle();
      n++;
    end
    m_axi_wready = 1'b1;
    check("drain_done", BW'(exp_q.size()), BW'(0));
    cycle();
    check("drain_idle", BW'(m_axi_wvalid), BW'(1'b0));
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0;
    aw_grant_valid = 1'b0; aw_grant_slave = 2'd0;
    s_axi_wvalid = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '0;
    m_axi_wready = 1'b1;
    en = 4'h0; gap_pct = 0; run_xfer = 0; run_idle = 0;
    reset_model();

    #12;
    check("rst_mvalid", BW'(m_axi_wvalid), BW'(1'b0));
    check("rst_mdata", BW'(m_axi_wdata), BW'(0));
    check("rst_mstrb", BW'(m_axi_wstrb), BW'(0));
    check("rst_mlast", BW'(m_axi_wlast), BW'(1'b0));
    check("rst_swready", BW'(s_axi_wready), BW'(0));
    check("rst_count", BW'(order_count), BW'(0));
    check("rst_awready", BW'(aw_grant_ready), BW'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Single 4-beat burst from slave 2
    add_burst(2, 4);
    en = 4'b0100; run_xfer = 0; run_idle = 0;
    grant(2);
    repeat (6) cycle();
    check("t1_beats", BW'(run_xfer), BW'(4));
    check("t1_idle", BW'(run_idle), BW'(0));

    // Back-to-back bursts in grant order 0,3,1
    add_burst(0, 2); add_burst(3, 2); add_burst(1, 2);
    en = 4'hf; run_xfer = 0; run_idle = 0;
    grant(0); grant(3); grant(1);
    repeat (8) cycle();
    check("t2_beats", BW'(run_xfer), BW'(6));
    check("t2_idle", BW'(run_idle), BW'(0));

    // Master stall mid-burst
    add_burst(0, 6);
    grant(0);
    cycle();
    check("t3_mvalid", BW'(m_axi_wvalid), BW'(1'b1));
    m_axi_wready = 1'b0;
    repeat (5) begin
      cycle();
      check("t3_hold", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, exp_q[0]);
      check("t3_no_ready", BW'(s_axi_wready), BW'(0));
    end
    m_axi_wready = 1'b1;
    drain(1'b0);

    // Fill the order FIFO, then pop and push in adjacent cycles
    en = 4'h0;
    for (int i = 0; i < 16; i++) begin
      kk = int'($urandom_range(3));
      add_burst(kk, 2);
      grant(kk);
    end
    check("t4_full_ready", BW'(aw_grant_ready), BW'(1'b0));
    check("t4_full_count", BW'(order_count), BW'(16));
    kk = int'($urandom_range(3));
    add_burst(kk, 2);
    aw_grant_valid = 1'b1; aw_grant_slave = 2'(kk);
    cycle();
    check("t4_17th_ignored", BW'(order_count), BW'(16));
    en = 4'hf;
    pushed = 1'b0; cnt_before = 16;
    for (int n = 0; n < 20 && !pushed; n++) begin
      cnt_before = int'(order_count);
      cycle();
    end
    check("t4_grant_taken", BW'(pushed), BW'(1'b1));
    check("t4_count_before", BW'(cnt_before), BW'(15));
    check("t4_count_after", BW'(order_count), BW'(16));
    aw_grant_valid = 1'b0;
    gap_pct = 20;
    drain(1'b1);

    // Random grants, lengths, slave gaps and master back-pressure
    gap_pct = 25;
    for (int i = 0; i < 12; i++) begin
      kk = int'($urandom_range(3));
      add_burst(kk, int'($urandom_range(1, 4)));
      m_axi_wready = ($urandom_range(99) < 70);
      grant(kk);
    end
    drain(1'b1);
    gap_pct = 0;

    // W data ahead of its grant
    add_burst(1, 3);
    en = 4'hf;
    repeat (3) begin
      cycle();
      check("t5_no_ready", BW'(s_axi_wready[1]), BW'(1'b0));
    end
    grant(1);
    #1;
    check("t5_ready", BW'(s_axi_wready), BW'(4'b0010));
    drain(1'b0);

    // Asynchronous reset mid-burst
    add_burst(2, 6);
    grant(2);
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_mvalid", BW'(m_axi_wvalid), BW'(1'b0));
    check("t6_count", BW'(order_count), BW'(0));
    check("t6_swready", BW'(s_axi_wready), BW'(0));
    check("t6_awready", BW'(aw_grant_ready), BW'(1'b1));
    reset_model();
    en = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    add_burst(3, 3);
    en = 4'hf; run_xfer = 0;
    grant(3);
    drain(1'b0);
    check("t6_beats", BW'(run_xfer), BW'(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
